// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hamming_pkg
// Description : Shared Hamming(12,8) definitions for the encoder and checker:
//               parity equations, syndrome-to-data-bit map, syndrome classes
//               and the checker status FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    // Checker status FSM
    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_DEGRADED = 2'd1,
        ST_ALARM    = 2'd2
    } state_e;

    // What a given syndrome means for the received word
    typedef enum logic [1:0] {
        NONE   = 2'd0,   // clean word
        PARITY = 2'd1,   // a parity bit flipped, data intact
        DATA   = 2'd2,   // a data bit flipped, correctable
        UNCORR = 2'd3    // syndrome points outside the 12-bit codeword
    } syn_class_e;

    // Marker for syndromes that do not address a data bit
    localparam logic [3:0] c_NO_BIT = 4'hF;

    // Indexed by syndrome: which data bit sits at that code position.
    // Data bits live at positions 3,5,6,7,9,10,11,12.
    localparam logic [15:0][3:0] c_SYN2BIT = {
        4'hF, 4'hF, 4'hF, 4'd7,   // 15..12
        4'd6, 4'd5, 4'd4, 4'hF,   // 11..8
        4'd3, 4'd2, 4'd1, 4'hF,   //  7..4
        4'd0, 4'hF, 4'hF, 4'hF    //  3..0
    };

    // Parity equations shared with the upstream encoder
    function automatic logic [3:0] hamming_parity(input logic [7:0] d);
        logic [3:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : hamming_checker_if
// Description : Word stream in / corrected stream out of the Hamming checker.
//               err_count is present only when HAMMING_ERR_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface hamming_checker_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic [3:0]       in_parity;
    logic             clear_alarm;
    logic             out_valid;
    logic [7:0]       out_data;
    logic [3:0]       syndrome;
    logic             err_corrected;
    logic             err_uncorrectable;
    logic             alarm;
`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] err_count;

    modport master (
        output in_valid, in_data, in_parity, clear_alarm,
        input  out_valid, out_data, syndrome, err_corrected,
               err_uncorrectable, alarm, err_count
    );
    modport slave (
        input  in_valid, in_data, in_parity, clear_alarm,
        output out_valid, out_data, syndrome, err_corrected,
               err_uncorrectable, alarm, err_count
    );
`else
    modport master (
        output in_valid, in_data, in_parity, clear_alarm,
        input  out_valid, out_data, syndrome, err_corrected,
               err_uncorrectable, alarm
    );
    modport slave (
        input  in_valid, in_data, in_parity, clear_alarm,
        output out_valid, out_data, syndrome, err_corrected,
               err_uncorrectable, alarm
    );
`endif
endinterface
`default_nettype wire

// File: rtl/hamming_syndrome_dec.sv
`default_nettype none
// ============================================================================
// Module      : hamming_syndrome_dec
// Description : Combinational syndrome decoder: correction mask for the data
//               word and the class of error the syndrome indicates.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_syndrome_dec
    import hamming_pkg::*;
(
    input  logic [3:0] syndrome_i,
    output logic [7:0] mask_o,
    output syn_class_e class_o
);

    logic [3:0] bit_idx;

    // Classify the syndrome and build a one-hot flip mask for data errors
    always_comb begin
        bit_idx = c_SYN2BIT[syndrome_i];
        mask_o  = '0;
        class_o = NONE;
        if (syndrome_i == 4'd0) begin
            class_o = NONE;
        end else if (syndrome_i > 4'd12) begin
            class_o = UNCORR;
        end else if (bit_idx == c_NO_BIT) begin
            class_o = PARITY;
        end else begin
            class_o                = DATA;
            mask_o[bit_idx[2:0]]   = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hamming_checker.sv
`default_nettype none
// ============================================================================
// Module      : hamming_checker
// Description : Hamming(12,8) checker/corrector with one-cycle latency, error
//               flags and a run-length status FSM raising a sticky alarm.
//               Optional saturating error counter: define HAMMING_ERR_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hamming_checker
    import hamming_pkg::*;
#(
    parameter int ALARM_THRESH = 3,
    parameter int CNT_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    hamming_checker_if.slave   bus
);

    generate
        if (ALARM_THRESH < 1 || ALARM_THRESH > 15) begin : g_bad_thresh
            $error("hamming_checker: ALARM_THRESH must be in 1..15");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("hamming_checker: CNT_W must be at least 1");
        end
    endgenerate

    localparam logic [3:0] c_THRESH = 4'(ALARM_THRESH);

    // ---------------------------------------------------------------- decode
    logic [3:0]  syn_d;
    logic [7:0]  mask;
    syn_class_e  cls;
    logic        word_err;
    logic [7:0]  out_data_d;
    logic        corr_d;
    logic        unc_d;

    assign syn_d    = hamming_parity(bus.in_data) ^ bus.in_parity;
    assign word_err = (syn_d != 4'd0);

    hamming_syndrome_dec u_dec (
        .syndrome_i (syn_d),
        .mask_o     (mask),
        .class_o    (cls)
    );

    assign out_data_d = bus.in_data ^ mask;
    assign corr_d     = (cls == PARITY) || (cls == DATA);
    assign unc_d      = (cls == UNCORR);

    // -------------------------------------------------------------- datapath
    logic        out_valid_q;
    logic [7:0]  out_data_q;
    logic [3:0]  syndrome_q;
    logic        corr_q;
    logic        unc_q;

    // Register the corrected word; payload and flags hold between valid words
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            syndrome_q  <= '0;
            corr_q      <= 1'b0;
            unc_q       <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                out_data_q <= out_data_d;
                syndrome_q <= syn_d;
                corr_q     <= corr_d;
                unc_q      <= unc_d;
            end
        end
    end

    // ------------------------------------------------------------ status FSM
    state_e      state_q;
    logic [3:0]  run_q;
    logic        alarm_q;
    logic [3:0]  run_inc;

    assign run_inc = run_q + 4'd1;

    // Count consecutive faulty valid words; clear_alarm restarts from OK
    // before the coincident word is evaluated
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OK;
            run_q   <= '0;
            alarm_q <= 1'b0;
        end else if (bus.clear_alarm) begin
            if (bus.in_valid && word_err) begin
                run_q <= 4'd1;
                if (c_THRESH == 4'd1) begin
                    state_q <= ST_ALARM;
                    alarm_q <= 1'b1;
                end else begin
                    state_q <= ST_DEGRADED;
                    alarm_q <= 1'b0;
                end
            end else begin
                state_q <= ST_OK;
                run_q   <= '0;
                alarm_q <= 1'b0;
            end
        end else if (bus.in_valid) begin
            case (state_q)
                ST_OK: begin
                    if (word_err) begin
                        run_q <= 4'd1;
                        if (c_THRESH == 4'd1) begin
                            state_q <= ST_ALARM;
                            alarm_q <= 1'b1;
                        end else begin
                            state_q <= ST_DEGRADED;
                        end
                    end
                end
                ST_DEGRADED: begin
                    if (word_err) begin
                        run_q <= run_inc;
                        if (run_inc >= c_THRESH) begin
                            state_q <= ST_ALARM;
                            alarm_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_OK;
                        run_q   <= '0;
                    end
                end
                ST_ALARM: begin
                    alarm_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_OK;
                    run_q   <= '0;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    assign bus.out_valid         = out_valid_q;
    assign bus.out_data          = out_data_q;
    assign bus.syndrome          = syndrome_q;
    assign bus.err_corrected     = corr_q & out_valid_q;
    assign bus.err_uncorrectable = unc_q & out_valid_q;
    assign bus.alarm             = alarm_q;

`ifdef HAMMING_ERR_CNT_EN
    logic [CNT_W-1:0] err_count_q;

    // Saturating count of faulty valid words; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (bus.in_valid && word_err && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_q <= err_count_q + CNT_W'(1);
        end
    end

    assign bus.err_count = err_count_q;
`endif

endmodule
`default_nettype wire

// File: doc/hamming_checker.md
# hamming_checker

Downstream stage of the counter/Hamming encoder. Takes each 8-bit count word plus its 4 Hamming(12,8) parity bits, recomputes the syndrome, corrects any single-bit error and emits the corrected word one cycle later with error flags. A small status FSM turns runs of consecutive faulty words into a sticky alarm. An optional saturating error counter supports fault-injection campaigns.

## Interface
- ALARM_THRESH, 3: consecutive erroneous words (corrected or uncorrectable) that raise alarm; legal 1..15
- CNT_W, 8: width of err_count
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  in_data/in_parity valid this cycle; no backpressure
- in_data  in  8  received data word d[7:0]
- in_parity  in  4  received parity p[3:0]
- clear_alarm  in  1  one-cycle pulse; clears alarm and run length
- out_valid  out  1  registered in_valid
- out_data  out  8  corrected data
- syndrome  out  4  syndrome of the word on out_data
- err_corrected  out  1  single-bit error fixed (data or parity bit)
- err_uncorrectable  out  1  syndrome 13..15; data passed through unmodified
- alarm  out  1  sticky alarm
- err_count  out  CNT_W  saturating count of erroneous words (HAMMING_ERR_CNT_EN only)

## Operation
- Code positions 1..12: parity at 1,2,4,8; d0..d7 at 3,5,6,7,9,10,11,12.
- Parity: p0=d0^d1^d3^d4^d6; p1=d0^d2^d3^d5^d6; p2=d1^d2^d3^d7; p3=d4^d5^d6^d7.
- syndrome = recomputed parity XOR in_parity; its value is the error position.
- 0: no error. 1,2,4,8: parity-bit error, data unchanged, err_corrected=1. 3,5,6,7,9..12: flip the mapped data bit, err_corrected=1. 13,14,15: err_uncorrectable=1, data unchanged.
- A word is erroneous when syndrome is non-zero.
- FSM states:
  - OK: alarm=0, run=0.
  - DEGRADED: 0<run<ALARM_THRESH.
  - ALARM: alarm=1, sticky.
- FSM transitions:
  - OK → DEGRADED on an erroneous valid word; go directly to ALARM if ALARM_THRESH=1.
  - DEGRADED → OK on a clean valid word (run cleared).
  - DEGRADED → ALARM when run reaches ALARM_THRESH.
  - ALARM stays until clear_alarm; clean words do not leave ALARM.
- clear_alarm together with a valid word: clear applies first, then the word is evaluated from OK. An erroneous word therefore leaves state DEGRADED with run=1, or ALARM if ALARM_THRESH=1.
- Cycles without in_valid do not advance the FSM or the run length.

## Timing
- Latency 1 cycle: the word sampled at edge N appears at edge N+1 with out_valid=1.
- Throughput 1 word/cycle, back-to-back.
- syndrome, flags and out_data update only on valid cycles and hold otherwise. err_corrected/err_uncorrectable are qualified by out_valid.
- alarm rises in the same cycle as out_valid for the threshold word. It falls the cycle after clear_alarm is sampled, unless the rule above re-raises it.
- Reset values: out_valid=0, out_data=0, syndrome=0, both flags=0, alarm=0, err_count=0, FSM=OK, run=0.
- Reset asserted mid-stream: all outputs clear immediately, asynchronously. The in-flight word is dropped.

## Configuration
- HAMMING_ERR_CNT_EN defined: err_count port and its register exist. The counter increments on every erroneous valid word and saturates at 2^CNT_W-1. clear_alarm does not clear it; only reset does.
- Not defined: port and logic absent; all other behaviour identical.

## Structure
- Shared package hamming_pkg holds:
  - parity-equation function
  - syndrome-to-bit-index map constant
  - FSM state enum
  - syndrome class constants (NONE, PARITY, DATA, UNCORR)
- The encoder upstream uses the same parity function.
- Natural sub-module: hamming_syndrome_dec, combinational. It maps syndrome to a correction mask and class; the top holds the registers and FSM.

## Test plan
- Clean word: in_data=0x2D, in_parity=4'b1000 → next cycle out_data=0x2D, syndrome=0, no flags, FSM OK.
- Data flip: in_data=0x2C, in_parity=4'b1000 → out_data=0x2D, syndrome=3, err_corrected=1.
- Parity flip: in_data=0x2D, in_parity=4'b1001 → out_data=0x2D, syndrome=1, err_corrected=1.
- Uncorrectable: in_data=0x2D, in_parity=4'b0101 → out_data=0x2D, syndrome=13, err_uncorrectable=1.
- Alarm (ALARM_THRESH=3): three consecutive 0x2C/1000 words → alarm=1 with the third out_valid. A following clean word leaves alarm=1. clear_alarm pulse → alarm=0 next cycle. Repeat with clear_alarm coincident with an error → DEGRADED, alarm=0.
- Counter and reset: with HAMMING_ERR_CNT_EN and CNT_W=2, five erroneous words → err_count=3 (saturated). Assert reset mid-stream → all outputs 0 immediately; first word after release yields correct output with 1-cycle latency.
